// File: rtl/write_traffic_gen_if.sv
// Engine-side bus between write_traffic_gen (master) and write_engine (slave).
//   start       : one-cycle pulse per burst
//   write_addr  : burst byte address, held for the whole burst
//   burst       : AWLEN encoding (beats = burst+1)
//   strobe      : byte enables, all ones
//   write_data  : current beat data
//   write_ready : one-cycle pulse per beat offered
//   write_resp  : engine pulse, AW accepted or one W beat accepted
//   write_end   : engine pulse, burst response received
interface write_traffic_gen_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8
) ();
  logic                    start;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic [LEN_WIDTH-1:0]    burst;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    write_ready;
  logic                    write_resp;
  logic                    write_end;

  modport master (
    output start, write_addr, burst, strobe, write_data, write_ready,
    input  write_resp, write_end
  );

  modport slave (
    input  start, write_addr, burst, strobe, write_data, write_ready,
    output write_resp, write_end
  );
endinterface

// File: rtl/write_traffic_gen.sv
// Stimulus sequencer for write_engine: issues cfg_num_bursts bursts of
// cfg_burst_len+1 beats, one beat and one burst outstanding at a time.
// Data word per beat is (seed + global beat index) replicated across lanes.
// Ports:
//   clk, resetn           : clock, synchronous active-low reset
//   cfg_*                 : run configuration, latched when cfg_start is accepted
//   busy/done/error       : run status (error = sticky timeout)
//   bursts_done           : bursts retired this run
//   cycle_count           : busy cycles this run, saturating
//   eng                   : engine bus (master side)
module write_traffic_gen #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_num_bursts,
  input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
  input  logic [31:0]           cfg_seed,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  bursts_done,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  write_traffic_gen_if.master   eng
);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int WW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ADDR, S_DATA, S_BEAT_WAIT, S_END_WAIT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  tmo_fire;
  logic [WW-1:0]         wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [31:0]           seed_q, gbeat;
  // one bit wider than len so the last-beat compare works at len=all ones
  logic [LEN_WIDTH:0]    beat;
  logic [31:0]           word;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Engine events take priority over a timeout expiring in the same cycle.
  always_comb begin
    logic wait_tmo;
    state_d  = state_q;
    tmo_fire = 1'b0;
    wait_tmo = (wait_cnt == WW'(TIMEOUT - 1));
    case (state_q)
      S_IDLE:  if (cfg_start) state_d = (cfg_num_bursts == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_ADDR;
      S_ADDR: begin
        if (eng.write_resp) state_d = S_DATA;
        else if (wait_tmo) begin state_d = S_DONE; tmo_fire = 1'b1; end
      end
      S_DATA: state_d = S_BEAT_WAIT;
      S_BEAT_WAIT: begin
        if (eng.write_resp) state_d = (beat == {1'b0, len_q}) ? S_END_WAIT : S_DATA;
        else if (wait_tmo) begin state_d = S_DONE; tmo_fire = 1'b1; end
      end
      S_END_WAIT: begin
        if (eng.write_end)
          state_d = ((bursts_done + CNT_WIDTH'(1)) == num_q) ? S_DONE : S_ISSUE;
        else if (wait_tmo) begin state_d = S_DONE; tmo_fire = 1'b1; end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    eng.start       = (state_q == S_ISSUE);
    eng.write_ready = (state_q == S_DATA);
  end

  // Data is a pure function of latched seed and gbeat, so it stays put
  // until gbeat advances on the beat ack.
  assign word           = seed_q + gbeat;
  assign eng.write_data = {LANES{word}};
  assign eng.write_addr = addr_q;
  assign eng.burst      = len_q;
  assign eng.strobe     = '1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt    <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      num_q       <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      gbeat       <= '0;
      beat        <= '0;
      bursts_done <= '0;
      cycle_count <= '0;
      error       <= 1'b0;
    end else begin
      wait_cnt <= (state_d != state_q) ? '0 : wait_cnt + WW'(1);
      if (state_q != S_IDLE && !(&cycle_count)) cycle_count <= cycle_count + CNT_WIDTH'(1);
      case (state_q)
        S_IDLE: if (cfg_start) begin
          stride_q    <= cfg_stride;
          num_q       <= cfg_num_bursts;
          len_q       <= cfg_burst_len;
          seed_q      <= cfg_seed;
          addr_q      <= cfg_base_addr;
          gbeat       <= '0;
          bursts_done <= '0;
          cycle_count <= '0;
          error       <= 1'b0;
        end
        S_ADDR: if (eng.write_resp) beat <= '0;
        S_BEAT_WAIT: if (eng.write_resp) begin
          gbeat <= gbeat + 32'd1;
          if (beat != {1'b0, len_q}) beat <= beat + (LEN_WIDTH+1)'(1);
        end
        S_END_WAIT: if (eng.write_end) begin
          bursts_done <= bursts_done + CNT_WIDTH'(1);
          addr_q      <= addr_q + stride_q;
        end
        default: ;
      endcase
      if (tmo_fire) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_write_traffic_gen.sv
module tb_write_traffic_gen;
  localparam int AW = 33, DW = 256, LW = 8, CW = 32, TMO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0, cfg_stride = '0;
  logic [CW-1:0] cfg_num_bursts = '0;
  logic [LW-1:0] cfg_burst_len = '0;
  logic [31:0]   cfg_seed = '0;
  logic          busy, done, error;
  logic [CW-1:0] bursts_done, cycle_count;

  write_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  write_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                      .CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_num_bursts(cfg_num_bursts), .cfg_burst_len(cfg_burst_len),
    .cfg_seed(cfg_seed), .busy(busy), .done(done), .error(error),
    .bursts_done(bursts_done), .cycle_count(cycle_count), .eng(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int mode_rand = 0, drop_resp = 0, withhold = -1, cur_len = 0, burst_idx = -1;
  int done_cnt = 0, lane_bad = 0;
  logic [AW-1:0] addr_q[$];
  logic [31:0]   word_q[$];

  function automatic int dly();
    return (mode_rand != 0) ? int'($urandom_range(0, 7)) : 0;
  endfunction

  // Engine model: acks each request d+1 cycles later (d=0 ideal, 0..7 random)
  initial begin
    int d, beat_m;
    logic [DW-1:0] cap;
    bus.write_resp = 1'b0;
    bus.write_end  = 1'b0;
    beat_m = 0;
    @(negedge clk);
    forever begin
      if (resetn && bus.start) begin
        burst_idx++;
        beat_m = 0;
        d = dly();
        repeat (d + 1) @(negedge clk);
        bus.write_resp = 1'b1;
        @(negedge clk);
        bus.write_resp = 1'b0;
      end else if (resetn && bus.write_ready) begin
        cap = bus.write_data;
        if (drop_resp != 0) @(negedge clk);
        else begin
          d = dly();
          repeat (d + 1) @(negedge clk);
          n_cmp++;
          if (bus.write_data !== cap) begin
            n_err++;
            $display("FAIL beat_stable got=%h exp=%h", bus.write_data[31:0], cap[31:0]);
          end
          bus.write_resp = 1'b1;
          @(negedge clk);
          bus.write_resp = 1'b0;
          beat_m++;
          if (beat_m == cur_len + 1 && burst_idx != withhold) begin
            d = dly();
            repeat (d) @(negedge clk);
            bus.write_end = 1'b1;
            @(negedge clk);
            bus.write_end = 1'b0;
          end
        end
      end else @(negedge clk);
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (bus.start) addr_q.push_back(bus.write_addr);
    if (bus.write_ready) begin
      word_q.push_back(bus.write_data[31:0]);
      for (int l = 1; l < DW/32; l++)
        if (bus.write_data[32*l +: 32] !== bus.write_data[31:0]) lane_bad++;
    end
    if (done) done_cnt++;
  end

  task automatic clear_mon();
    addr_q.delete(); word_q.delete(); done_cnt = 0; lane_bad = 0;
  endtask

  task automatic kick(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                      input int num, input int len, input logic [31:0] seed);
    @(negedge clk);
    cfg_base_addr = base; cfg_stride = stride; cfg_num_bursts = CW'(num);
    cfg_burst_len = LW'(len); cfg_seed = seed; cur_len = len; burst_idx = -1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string nm);
    int k = 0;
    while (done_cnt == 0 && k < max) begin @(negedge clk); k++; end
    n_cmp++;
    if (done_cnt == 0) begin n_err++; $display("FAIL %s_timeout got=no_done exp=done", nm); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, error, bus.start, bus.write_ready} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, error, bus.start, bus.write_ready}); end
    n_cmp++; if (bus.write_addr !== '0 || bus.burst !== '0) begin
      n_err++; $display("FAIL reset_addr got=%h/%h exp=0/0", bus.write_addr, bus.burst); end
    n_cmp++; if (bus.write_data !== '0) begin
      n_err++; $display("FAIL reset_data got=%h exp=0", bus.write_data[31:0]); end
    n_cmp++; if (bursts_done !== '0 || cycle_count !== '0) begin
      n_err++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bursts_done, cycle_count); end
    n_cmp++; if (bus.strobe !== '1) begin
      n_err++; $display("FAIL reset_strobe got=%h exp=all_ones", bus.strobe); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea; logic [31:0] ew;
    clear_mon(); mode_rand = 0; withhold = -1; drop_resp = 0;
    kick(33'h1000, 33'h400, 3, 3, 32'hA5A50000);
    wait_done(300, "basic");
    n_cmp++; if (addr_q.size() != 3) begin n_err++; $display("FAIL basic_starts got=%0d exp=3", addr_q.size()); end
    for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
      ea = 33'h1000 + 33'h400 * i;
      n_cmp++; if (addr_q[i] !== ea) begin n_err++; $display("FAIL basic_addr%0d got=%h exp=%h", i, addr_q[i], ea); end
    end
    n_cmp++; if (word_q.size() != 12) begin n_err++; $display("FAIL basic_beats got=%0d exp=12", word_q.size()); end
    for (int i = 0; i < 12 && i < word_q.size(); i++) begin
      ew = 32'hA5A50000 + i;
      n_cmp++; if (word_q[i] !== ew) begin n_err++; $display("FAIL basic_data%0d got=%h exp=%h", i, word_q[i], ew); end
    end
    n_cmp++; if (lane_bad != 0) begin n_err++; $display("FAIL basic_lanes got=%0d exp=0", lane_bad); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    n_cmp++; if (bursts_done !== 32'd3 || error !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_status got=%0d/%b/%b exp=3/0/0", bursts_done, error, busy); end
    n_cmp++; if (cycle_count !== 32'd34) begin n_err++; $display("FAIL basic_cycles got=%0d exp=34", cycle_count); end
  endtask

  task automatic test_zero();
    int lat = 1;
    clear_mon();
    kick(33'h2000, 33'h10, 0, 3, 32'h1);
    while (done !== 1'b1 && lat < 4) begin @(negedge clk); lat++; end
    n_cmp++; if (lat > 2) begin n_err++; $display("FAIL zero_latency got=%0d exp=<=2", lat); end
    repeat (4) @(negedge clk);
    n_cmp++; if (addr_q.size() != 0) begin n_err++; $display("FAIL zero_starts got=%0d exp=0", addr_q.size()); end
    n_cmp++; if (done_cnt != 1 || bursts_done !== '0) begin
      n_err++; $display("FAIL zero_status got=%0d/%0d exp=1/0", done_cnt, bursts_done); end
    n_cmp++; if (cycle_count !== 32'd1) begin n_err++; $display("FAIL zero_cycles got=%0d exp=1", cycle_count); end
  endtask

  task automatic test_back_to_back();
    int bad = 0, first = -1;
    logic [31:0] seed = 32'hFFFF_FF00;
    clear_mon(); mode_rand = 1;
    kick(33'h4000, 33'h2000, 2, 255, seed);
    repeat (20) @(negedge clk);
    cfg_num_bursts = 5; cfg_seed = 32'h1234; cfg_start = 1'b1;   // must be ignored
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done(12000, "b2b");
    mode_rand = 0;
    n_cmp++; if (word_q.size() != 512) begin n_err++; $display("FAIL b2b_beats got=%0d exp=512", word_q.size()); end
    for (int i = 0; i < word_q.size(); i++)
      if (word_q[i] !== seed + 32'(i)) begin bad++; if (first < 0) first = i; end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_data got=%0d_bad(first %0d) exp=0", bad, first); end
    n_cmp++; if (addr_q.size() != 2 || addr_q[0] !== 33'h4000 || addr_q[addr_q.size()-1] !== 33'h6000) begin
      n_err++; $display("FAIL b2b_addr got=%0d_starts exp=2 at 4000/6000", addr_q.size()); end
    n_cmp++; if (done_cnt != 1 || bursts_done !== 32'd2 || error !== 1'b0) begin
      n_err++; $display("FAIL b2b_status got=%0d/%0d/%b exp=1/2/0", done_cnt, bursts_done, error); end
  endtask

  task automatic test_timeout();
    clear_mon(); withhold = 1;
    kick(33'h100, 33'h100, 3, 1, 32'h10);
    wait_done(300, "tmo");
    withhold = -1;
    n_cmp++; if (error !== 1'b1 || bursts_done !== 32'd1 || done_cnt != 1) begin
      n_err++; $display("FAIL tmo_status got=%b/%0d/%0d exp=1/1/1", error, bursts_done, done_cnt); end
    n_cmp++; if (cycle_count !== 32'd30) begin n_err++; $display("FAIL tmo_cycles got=%0d exp=30", cycle_count); end
    clear_mon();
    kick(33'h100, 33'h100, 1, 0, 32'h10);
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL tmo_clear got=%b/%b exp=0/1", error, busy); end
    wait_done(100, "tmo_rerun");
    n_cmp++; if (error !== 1'b0 || bursts_done !== 32'd1) begin
      n_err++; $display("FAIL tmo_rerun got=%b/%0d exp=0/1", error, bursts_done); end
  endtask

  task automatic test_wrap();
    clear_mon();
    kick(33'h1_FFFF_FC00, 33'h400, 2, 0, 32'h0);
    wait_done(100, "wrap");
    n_cmp++; if (addr_q.size() != 2) begin n_err++; $display("FAIL wrap_starts got=%0d exp=2", addr_q.size()); end
    else begin
      n_cmp++; if (addr_q[0] !== 33'h1_FFFF_FC00) begin n_err++; $display("FAIL wrap_addr0 got=%h exp=1fffffc00", addr_q[0]); end
      n_cmp++; if (addr_q[1] !== 33'h0) begin n_err++; $display("FAIL wrap_addr1 got=%h exp=0", addr_q[1]); end
    end
    n_cmp++; if (bus.write_addr !== 33'h400) begin n_err++; $display("FAIL wrap_final got=%h exp=400", bus.write_addr); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_mon(); drop_resp = 1;
    kick(33'h800, 33'h40, 2, 3, 32'h55);
    while (bus.write_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (bus.write_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got=0 exp=1"); end
    @(negedge clk);                   // now waiting for the beat ack
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, done, error, bus.start, bus.write_ready} !== 5'b0 || bus.write_data !== '0 || bus.write_addr !== '0) begin
      n_err++; $display("FAIL rmid_outputs got=%b/%h/%h exp=0", {busy, done, error, bus.start, bus.write_ready}, bus.write_data[31:0], bus.write_addr); end
    n_cmp++; if (bursts_done !== '0 || cycle_count !== '0 || bus.burst !== '0) begin
      n_err++; $display("FAIL rmid_counts got=%0d/%0d/%0d exp=0", bursts_done, cycle_count, bus.burst); end
    repeat (2) @(negedge clk);
    resetn = 1'b1; drop_resp = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL rmid_nodone got=%0d exp=0", done_cnt); end
    clear_mon();
    kick(33'h800, 33'h40, 1, 1, 32'h77);
    wait_done(100, "rmid_rerun");
    n_cmp++; if (word_q.size() != 2 || word_q[0] !== 32'h77 || word_q[word_q.size()-1] !== 32'h78) begin
      n_err++; $display("FAIL rmid_data got=%0d_beats exp=2 (77,78)", word_q.size()); end
    n_cmp++; if (bursts_done !== 32'd1 || error !== 1'b0 || done_cnt != 1) begin
      n_err++; $display("FAIL rmid_status got=%0d/%b/%0d exp=1/0/1", bursts_done, error, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
